flow_unit: RTL and testbench
============================

# flow_unit

Program-flow stage sitting directly downstream of the ALU: registers the ALU's zero/sign/carry flags into a 20-bit status register, owns the 20-bit program counter, and executes the program-flow operation class. The class covers NOP, TRAP, JMP, JZ, JS, JZS, LDSR and XORSR. It gives the conditional-jump instructions a stable, registered view of the flags produced by the logic, shift and comparison circuits, and stalls issue while entering trap mode.

## Interface
- WIDTH, 20, word width of pc, sr, epc, target
- RESET_PC, 20'h00000, pc value after reset
- TRAP_VEC, 20'hFFF00, pc loaded on trap entry
- TRAP_STALL, 2, cycles op_ready is held low after trap entry/return (>=1)

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- op_valid  in  1  operation presented this cycle
- opcode  in  3  0 NOP, 1 TRAP, 2 JMP, 3 JZ, 4 JS, 5 JZS, 6 LDSR, 7 XORSR
- target  in  WIDTH  jump target / LDSR value / XORSR mask
- flag_valid  in  1  ALU flags valid this cycle
- flag_zero  in  1  ALU zero
- flag_sign  in  1  ALU sign
- flag_carry  in  1  ALU carry
- op_ready  out  1  stage accepts an op this cycle
- pc  out  WIDTH  program counter (registered)
- sr  out  WIDTH  status register: [0] Z, [1] S, [2] C, [3] T (trap mode), [19:4] general
- epc  out  WIDTH  saved return pc
- branch_taken  out  1  one-cycle pulse: previous accepted op redirected pc

## Operation
- Accept = op_valid && op_ready, sampled at rising clk. op_valid with op_ready low is ignored; the upstream holds it.
- Sequential (non-redirect) pc update: pc <= pc + 1 mod 2^WIDTH; 20'hFFFFF wraps to 20'h00000.
- NOP: sequential pc.
- JMP: pc <= target.
- JZ / JS / JZS: taken if sr[0] / sr[1] / (sr[0]|sr[1]) respectively; taken -> pc <= target, else sequential. Conditions use the current registered sr, never same-cycle flag inputs.
- LDSR: sr <= target; sequential pc.
- XORSR: sr <= sr ^ target; sequential pc.
- TRAP with sr[3]=0 (entry): epc <= pc + 1 (wrapped); pc <= TRAP_VEC; sr[3] <= 1; enter STALL.
- TRAP with sr[3]=1 (return): pc <= epc; sr[3] <= 0; enter STALL.
- Flag capture: flag_valid -> sr[2:0] <= {flag_carry, flag_sign, flag_zero}; sr[19:3] are untouched.
- Priority on the same edge: an accepted LDSR/XORSR overrides flag_valid for all bits. An accepted TRAP's sr[3] write merges with the flag capture.
- branch_taken <= 1 for exactly the cycle after an accepted taken jump or any accepted TRAP; 0 otherwise.
- FSM states:
  - RUN: op_ready=1. Accepted TRAP -> STALL, cnt <= TRAP_STALL-1.
  - STALL: op_ready=0. cnt==0 -> RUN, else cnt-1. Flag capture remains active.

## Timing
- Reset (rst high at an edge): pc=RESET_PC, sr=0, epc=0, branch_taken=0, state RUN, cnt=0. op_ready=0 while rst high and 1 on the first cycle after.
- rst mid-STALL aborts the stall; the next cycle is RUN with reset values.
- Latency: every accepted op's effect on pc/sr/epc is visible 1 cycle after its accepting edge.
- Back-to-back acceptance every cycle in RUN; a JZ immediately after a flag_valid sees the newly captured flags.
- Trap: exactly TRAP_STALL cycles with op_ready=0 follow the accepting edge, then op_ready=1.
- op_ready is a function of state and rst only, never of op_valid.

## Test plan
- Reset/sequential: rst 1 cycle, then 3 NOPs -> pc 0,1,2,3; sr=0; op_ready=1 after reset; pc=20'hFFFFF + NOP -> 20'h00000.
- Conditional jumps: flag_valid with Z=1,S=0 then JZ target=20'h00400 -> pc=20'h00400, branch_taken pulse. JS target=20'h00800 -> not taken, pc=20'h00401. JZS target=20'h00010 -> taken.
- Same-cycle hazard: sr[0]=0, JZ accepted together with flag_valid Z=1 -> not taken, and sr[0]=1 next cycle.
- Status ops: LDSR 20'hABCD5 with simultaneous flag_valid -> sr=20'hABCD5. XORSR 20'h0000F -> sr=20'hABCDA.
- Trap round trip: pc=20'h00123, TRAP -> pc=20'hFFF00, epc=20'h00124, sr[3]=1, op_ready low 2 cycles with held op ignored. Second TRAP -> pc=20'h00124, sr[3]=0.
- Reset mid-stall: rst asserted in first STALL cycle -> next cycle pc=RESET_PC, sr=0, epc=0, op_ready=1.

Source files
------------

// File: rtl/flow_unit.sv
// Program-flow stage: owns pc, status register and saved return pc.
// It executes NOP/TRAP/JMP/JZ/JS/JZS/LDSR/XORSR and stalls issue on trap entry and return.
module flow_unit #(
  parameter int                WIDTH      = 20,
  parameter logic [WIDTH-1:0]  RESET_PC   = 20'h00000,
  parameter logic [WIDTH-1:0]  TRAP_VEC   = 20'hFFF00,
  parameter int                TRAP_STALL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] target,
  input  logic             flag_valid,
  input  logic             flag_zero,
  input  logic             flag_sign,
  input  logic             flag_carry,
  output logic             op_ready,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] sr,
  output logic [WIDTH-1:0] epc,
  output logic             branch_taken
);

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_TRAP  = 3'd1;
  localparam logic [2:0] OP_JMP   = 3'd2;
  localparam logic [2:0] OP_JZ    = 3'd3;
  localparam logic [2:0] OP_JS    = 3'd4;
  localparam logic [2:0] OP_JZS   = 3'd5;
  localparam logic [2:0] OP_LDSR  = 3'd6;
  localparam logic [2:0] OP_XORSR = 3'd7;

  localparam int              CNT_W    = (TRAP_STALL > 1) ? $clog2(TRAP_STALL) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TRAP_STALL - 1);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  pc_q, pc_d;
  logic [WIDTH-1:0]  sr_q, sr_d;
  logic [WIDTH-1:0]  epc_q, epc_d;
  logic              branch_q, branch_d;

  logic              accept;
  logic              jump_cond;
  logic [WIDTH-1:0]  pc_seq;

  // op_ready depends only on state and rst, never on op_valid.
  assign op_ready = (state_q == ST_RUN) && !rst;
  assign accept   = op_valid && op_ready;
  assign pc_seq   = pc_q + WIDTH'(1);

  // Jump conditions read the registered flags only.
  always_comb begin
    jump_cond = 1'b0;
    case (opcode)
      OP_JMP:  jump_cond = 1'b1;
      OP_JZ:   jump_cond = sr_q[0];
      OP_JS:   jump_cond = sr_q[1];
      OP_JZS:  jump_cond = sr_q[0] | sr_q[1];
      default: jump_cond = 1'b0;
    endcase
  end

  always_comb begin
    pc_d     = pc_q;
    sr_d     = sr_q;
    epc_d    = epc_q;
    branch_d = 1'b0;
    state_d  = state_q;
    cnt_d    = cnt_q;

    if (flag_valid) begin
      sr_d[2:0] = {flag_carry, flag_sign, flag_zero};
    end else begin
      sr_d[2:0] = sr_q[2:0];
    end

    // Status writes override the flag capture; TRAP only touches sr[3].
    if (accept) begin
      case (opcode)
        OP_NOP: begin
          pc_d = pc_seq;
        end
        OP_TRAP: begin
          branch_d = 1'b1;
          sr_d[3]  = ~sr_q[3];
          if (sr_q[3]) begin
            pc_d = epc_q;
          end else begin
            pc_d  = TRAP_VEC;
            epc_d = pc_seq;
          end
        end
        OP_JMP, OP_JZ, OP_JS, OP_JZS: begin
          if (jump_cond) begin
            pc_d     = target;
            branch_d = 1'b1;
          end else begin
            pc_d = pc_seq;
          end
        end
        OP_LDSR: begin
          pc_d = pc_seq;
          sr_d = target;
        end
        OP_XORSR: begin
          pc_d = pc_seq;
          sr_d = sr_q ^ target;
        end
        default: begin
          pc_d = pc_seq;
        end
      endcase
    end else begin
      pc_d = pc_q;
    end

    case (state_q)
      ST_RUN: begin
        if (accept && (opcode == OP_TRAP)) begin
          state_d = ST_STALL;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_STALL: begin
        if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      pc_q     <= RESET_PC;
      sr_q     <= '0;
      epc_q    <= '0;
      branch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pc_q     <= pc_d;
      sr_q     <= sr_d;
      epc_q    <= epc_d;
      branch_q <= branch_d;
    end
  end

  assign pc           = pc_q;
  assign sr           = sr_q;
  assign epc          = epc_q;
  assign branch_taken = branch_q;

endmodule

// File: tb/tb_flow_unit.sv
// Table-driven bench for flow_unit: directed vectors with hand-computed results,
// plus hand-written sequences for stall length and op_ready dependencies.
module tb_flow_unit;

  logic        clk = 1'b0;
  logic        rst, op_valid, flag_valid, flag_zero, flag_sign, flag_carry;
  logic [2:0]  opcode;
  logic [19:0] target;
  logic        op_ready, branch_taken;
  logic [19:0] pc, sr, epc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  flow_unit dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .opcode(opcode), .target(target),
    .flag_valid(flag_valid), .flag_zero(flag_zero), .flag_sign(flag_sign),
    .flag_carry(flag_carry), .op_ready(op_ready), .pc(pc), .sr(sr), .epc(epc),
    .branch_taken(branch_taken)
  );

  typedef struct {
    logic        rst;
    logic        vld;
    logic [2:0]  op;
    logic [19:0] tgt;
    logic        fv, fz, fs, fc;
    logic [19:0] e_pc, e_sr, e_epc;
    logic        e_bt, e_rdy;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic r, logic v, logic [2:0] o, logic [19:0] t,
                              logic fv, logic fz, logic fs, logic fc,
                              logic [19:0] p, logic [19:0] s, logic [19:0] e,
                              logic bt, logic rdy);
    vec_t x;
    x.rst = r; x.vld = v; x.op = o; x.tgt = t;
    x.fv = fv; x.fz = fz; x.fs = fs; x.fc = fc;
    x.e_pc = p; x.e_sr = s; x.e_epc = e; x.e_bt = bt; x.e_rdy = rdy;
    return x;
  endfunction

  task automatic chk(input string name, input int idx, input logic [19:0] got, input logic [19:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %05h expected %05h", name, idx, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; op_valid = v.vld; opcode = v.op; target = v.tgt;
    flag_valid = v.fv; flag_zero = v.fz; flag_sign = v.fs; flag_carry = v.fc;
  endtask

  localparam logic [2:0] NOP = 3'd0, TRAP = 3'd1, JMP = 3'd2, JZ = 3'd3,
                         JS = 3'd4, JZS = 3'd5, LDSR = 3'd6, XORSR = 3'd7;

  initial begin
    int n;
    // rst vld op tgt fv z s c | pc sr epc bt rdy
    tv.push_back(mk(1'b1, 1'b0, NOP,   20'h00000, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00000, 20'h00000, 20'h00000, 1'b0, 1'b0));
    tv.push_back(mk(1'b0, 1'b1, NOP,   20'h00000, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00001, 20'h00000, 20'h00000, 1'b0, 1'b1));
    tv.push_back(mk(1'b0, 1'b1, NOP,   20'h00000, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00002, 20'h00000, 20'h00000, 1'b0, 1'b1));
    tv.push_back(mk(1'b0, 1'b1, NOP,   20'h00000, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00003, 20'h00000, 20'h00000, 1'b0, 1'b1));
    tv.push_back(mk(1'b0, 1'b1, JMP,   20'hFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 20'hFFFFF, 20'h00000, 20'h00000, 1'b1, 1'b1));
    tv.push_back(mk(1'b0, 1'b1, NOP,   20'h00000, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00000, 20'h00000, 20'h00000, 1'b0, 1'b1));
    tv.push_back(mk(1'b0, 1'b0, JMP,   20'h00777, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00000, 20'h00000, 20'h00000, 1'b0, 1'b1));
    tv.push_back(mk(1'b0, 1'b0, NOP,   20'h00000, 1'b1, 1'b1, 1'b0, 1'b0, 20'h00000, 20'h00001, 20'h00000, 1'b0, 1'b1));
    tv.push_back(mk(1'b0, 1'b1, JZ,    20'h00400, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00400, 20'h00001, 20'h00000, 1'b1, 1'b1));
    tv.push_back(mk(1'b0, 1'b1, JS,    20'h00800, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00401, 20'h00001, 20'h00000, 1'b0, 1'b1));
    tv.push_back(mk(1'b0, 1'b1, JZS,   20'h00010, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00010, 20'h00001, 20'h00000, 1'b1, 1'b1));
    tv.push_back(mk(1'b0, 1'b0, NOP,   20'h00000, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00010, 20'h00000, 20'h00000, 1'b0, 1'b1));
    tv.push_back(mk(1'b0, 1'b1, JZ,    20'h00400, 1'b1, 1'b1, 1'b0, 1'b0, 20'h00011, 20'h00001, 20'h00000, 1'b0, 1'b1));
    tv.push_back(mk(1'b0, 1'b1, LDSR,  20'hABCD5, 1'b1, 1'b0, 1'b1, 1'b1, 20'h00012, 20'hABCD5, 20'h00000, 1'b0, 1'b1));
    tv.push_back(mk(1'b0, 1'b1, XORSR, 20'h0000F, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00013, 20'hABCDA, 20'h00000, 1'b0, 1'b1));
    tv.push_back(mk(1'b0, 1'b1, LDSR,  20'h00000, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00014, 20'h00000, 20'h00000, 1'b0, 1'b1));
    tv.push_back(mk(1'b0, 1'b0, NOP,   20'h00000, 1'b1, 1'b0, 1'b1, 1'b0, 20'h00014, 20'h00002, 20'h00000, 1'b0, 1'b1));
    tv.push_back(mk(1'b0, 1'b1, JS,    20'h00777, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00777, 20'h00002, 20'h00000, 1'b1, 1'b1));
    tv.push_back(mk(1'b0, 1'b1, JMP,   20'h00123, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00123, 20'h00002, 20'h00000, 1'b1, 1'b1));
    tv.push_back(mk(1'b0, 1'b1, TRAP,  20'h00000, 1'b0, 1'b0, 1'b0, 1'b0, 20'hFFF00, 20'h0000A, 20'h00124, 1'b1, 1'b0));
    tv.push_back(mk(1'b0, 1'b1, JMP,   20'h55555, 1'b1, 1'b1, 1'b0, 1'b0, 20'hFFF00, 20'h00009, 20'h00124, 1'b0, 1'b0));
    tv.push_back(mk(1'b0, 1'b1, JMP,   20'h55555, 1'b0, 1'b0, 1'b0, 1'b0, 20'hFFF00, 20'h00009, 20'h00124, 1'b0, 1'b1));
    tv.push_back(mk(1'b0, 1'b1, TRAP,  20'h00000, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00124, 20'h00001, 20'h00124, 1'b1, 1'b0));
    tv.push_back(mk(1'b0, 1'b0, NOP,   20'h00000, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00124, 20'h00001, 20'h00124, 1'b0, 1'b0));
    tv.push_back(mk(1'b0, 1'b0, NOP,   20'h00000, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00124, 20'h00001, 20'h00124, 1'b0, 1'b1));
    tv.push_back(mk(1'b0, 1'b1, TRAP,  20'h00000, 1'b0, 1'b0, 1'b0, 1'b0, 20'hFFF00, 20'h00009, 20'h00125, 1'b1, 1'b0));
    tv.push_back(mk(1'b1, 1'b1, JMP,   20'h00333, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00000, 20'h00000, 20'h00000, 1'b0, 1'b0));
    tv.push_back(mk(1'b0, 1'b0, NOP,   20'h00000, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00000, 20'h00000, 20'h00000, 1'b0, 1'b1));

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      drive(tv[i]);
      @(posedge clk);
      #1;
      chk("pc", i, pc, tv[i].e_pc);
      chk("sr", i, sr, tv[i].e_sr);
      chk("epc", i, epc, tv[i].e_epc);
      chk("branch_taken", i, {19'd0, branch_taken}, {19'd0, tv[i].e_bt});
      chk("op_ready", i, {19'd0, op_ready}, {19'd0, tv[i].e_rdy});
    end

    // Stall length after a trap entry from pc 0.
    @(negedge clk);
    drive(mk(1'b0, 1'b1, TRAP, 20'h00000, 1'b0, 1'b0, 1'b0, 1'b0, 20'h0, 20'h0, 20'h0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    chk("trap_pc", 100, pc, 20'hFFF00);
    chk("trap_epc", 100, epc, 20'h00001);
    op_valid = 1'b0;
    #1;
    chk("ready_vs_valid", 101, {19'd0, op_ready}, 20'h00000);
    n = 0;
    while (!op_ready && n < 10) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("stall_cycles", 102, 20'(n), 20'd2);

    // op_ready drops combinationally with rst while in RUN.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("ready_in_rst", 103, {19'd0, op_ready}, 20'h00000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 104, {19'd0, op_ready}, 20'h00001);
    chk("pc_after_rst", 104, pc, 20'h00000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
